// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and helpers for the key schedule and cipher core.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_RND_W = 4;

  typedef logic [AES_KEY_W-1:0]  rkey_t;
  typedef logic [AES_WORD_W-1:0] word_t;
  typedef logic [AES_RND_W-1:0]  rnd_t;

  // Round key viewed as four words, word 0 in the most significant position.
  typedef struct packed {
    word_t w0;
    word_t w1;
    word_t w2;
    word_t w3;
  } rk_words_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } ks_state_e;

  // Multiply by x in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expand_128_if.sv
// Load/advance request and round-key presentation bundle for the key schedule.
interface aes_key_expand_128_if;
  import aes_pkg::*;

  logic  ld;
  rkey_t key;
  logic  adv;
  rkey_t rk;
  rnd_t  rnd;
  logic  rk_valid;
  logic  done;

  modport master (
    output ld, key, adv,
    input  rk, rnd, rk_valid, done
  );

  modport slave (
    input  ld, key, adv,
    output rk, rnd, rk_valid, done
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expand_128.sv
// AES-128 key schedule: presents round keys 0..10 one per advance request.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  aes_key_expand_128_if.slave  bus
);

  ks_state_e   state_q, state_d;
  rkey_t       rk_q, rk_d;
  rnd_t        rnd_q, rnd_d;
  logic [7:0]  rcon_q, rcon_d;
  logic        rk_valid_q, rk_valid_d;
  logic        done_q, done_d;

  rk_words_t   cur_w;
  rk_words_t   nxt_w;
  word_t       rot_w;
  word_t       sub_w;
  word_t       t_w;

  assign cur_w = rk_words_t'(rk_q);
  assign rot_w = {cur_w.w3[23:0], cur_w.w3[31:24]};

  // SubWord: one S-box per byte of the rotated last word.
  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*i +: 8]),
      .out_byte (sub_w[8*i +: 8])
    );
  end

  // Word XOR chain producing the following round key from the current one.
  always_comb begin
    t_w      = sub_w ^ {rcon_q, 24'h000000};
    nxt_w.w0 = cur_w.w0 ^ t_w;
    nxt_w.w1 = cur_w.w1 ^ nxt_w.w0;
    nxt_w.w2 = cur_w.w2 ^ nxt_w.w1;
    nxt_w.w3 = cur_w.w3 ^ nxt_w.w2;
  end

  // Next-state: load restarts from any state and beats a same-cycle advance.
  always_comb begin
    state_d    = state_q;
    rk_d       = rk_q;
    rnd_d      = rnd_q;
    rcon_d     = rcon_q;
    rk_valid_d = rk_valid_q;
    done_d     = done_q;
    if (bus.ld) begin
      state_d    = ST_RUN;
      rk_d       = bus.key;
      rnd_d      = '0;
      rcon_d     = 8'h01;
      rk_valid_d = 1'b1;
      done_d     = 1'b0;
    end else if (bus.adv && (state_q == ST_RUN)) begin
      rk_d   = rkey_t'(nxt_w);
      rnd_d  = rnd_q + AES_RND_W'(1);
      rcon_d = xtime(rcon_q);
      if (rnd_q == AES_RND_W'(AES_NR - 1)) begin
        state_d = ST_LAST;
        done_d  = 1'b1;
      end
    end
  end

  // State, rcon and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rk_q       <= '0;
      rnd_q      <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_q       <= rk_d;
      rnd_q      <= rnd_d;
      rcon_q     <= rcon_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
    end
  end

  assign bus.rk       = rk_q;
  assign bus.rnd      = rnd_q;
  assign bus.rk_valid = rk_valid_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for the AES-128 key schedule against a GF(2^8) reference model.
module tb_aes_key_expand_128;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [7:0]   sb [256];
  logic [127:0] sched [11];

  aes_key_expand_128_if bus ();

  aes_key_expand_128 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Word-array FIPS-197 expansion of a 128-bit key into sched[0..10].
  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    int rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 1;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {8'(rc), 24'h0};
        rc = rc * 2;
        if (rc > 255) rc = (rc - 256) ^ 'h1b;
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++) sched[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k);
    bus.ld = 1'b1; bus.key = k; bus.adv = 1'b0;
    tick();
    bus.ld = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [133:0] got, exp;
    rst = 1'b0; bus.ld = 1'b1; bus.adv = 1'b1; bus.key = FIPS_KEY;
    tick(); tick();
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_state: got %h exp %h", got, exp); end
    rst = 1'b1; bus.ld = 1'b0; bus.adv = 1'b1;
    tick(); tick();
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL idle_adv_ignored: got %h exp %h", got, exp); end
    bus.adv = 1'b0;
  endtask

  task automatic test_fips_back_to_back();
    logic [133:0] got, exp;
    expand(FIPS_KEY);
    n_checks++;
    if (sched[1] !== 128'ha0fafe1788542cb123a339392a6c7605 || sched[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_fail++; $display("FAIL model_fips: r1 %h r10 %h", sched[1], sched[10]);
    end
    do_load(FIPS_KEY);
    for (int r = 0; r <= 10; r++) begin
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      exp = {sched[r], 4'(r), 1'b1, (r == 10)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL fips_b2b r%0d: got %h exp %h", r, got, exp); end
      if (r == 1) begin
        n_checks++;
        if (bus.rk !== 128'ha0fafe1788542cb123a339392a6c7605) begin
          n_fail++; $display("FAIL fips_r1_const: got %h", bus.rk);
        end
      end
      if (r == 10) begin
        n_checks++;
        if (bus.rk !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || bus.done !== 1'b1) begin
          n_fail++; $display("FAIL fips_r10_const: got %h done %b", bus.rk, bus.done);
        end
      end
      bus.adv = 1'b1;
      if (r < 10) tick();
    end
    // Keep advancing in LAST: nothing may move.
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      exp = {sched[10], 4'd10, 1'b1, 1'b1};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL last_hold %0d: got %h exp %h", i, got, exp); end
    end
    bus.adv = 1'b0;
  endtask

  task automatic test_zero_key();
    logic [133:0] got, exp;
    do_load('0);
    bus.adv = 1'b1; tick(); bus.adv = 1'b0;
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    exp = {128'h62636363626363636263636362636363, 4'd1, 1'b1, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL zero_key_r1: got %h exp %h", got, exp); end
  endtask

  task automatic test_random_gaps();
    logic [133:0] got, exp;
    int idx;
    expand(FIPS_KEY);
    do_load(FIPS_KEY);
    idx = 0;
    for (int cyc = 0; cyc < 300 && idx < 10; cyc++) begin
      bus.adv = ($urandom_range(0, 2) == 0);
      tick();
      if (bus.adv && idx < 10) idx++;
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      exp = {sched[idx], 4'(idx), 1'b1, (idx == 10)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL gaps cyc%0d: got %h exp %h", cyc, got, exp); end
    end
    bus.adv = 1'b0;
    n_checks++;
    if (idx != 10) begin n_fail++; $display("FAIL gaps_budget: reached %0d exp 10", idx); end
  endtask

  task automatic test_reload_mid();
    logic [133:0] got, exp;
    logic [127:0] k1, k2;
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_load(k1);
    bus.adv = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.adv = 1'b0;
    bus.ld = 1'b1; bus.key = k2; tick(); bus.ld = 1'b0;
    expand(k2);
    for (int r = 0; r <= 10; r++) begin
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      exp = {sched[r], 4'(r), 1'b1, (r == 10)};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reload_mid r%0d: got %h exp %h", r, got, exp); end
      bus.adv = 1'b1;
      if (r < 10) tick();
    end
    bus.adv = 1'b0;
  endtask

  task automatic test_ld_adv_same();
    logic [133:0] got, exp;
    logic [127:0] k2;
    k2 = {$urandom, $urandom, $urandom, $urandom};
    do_load(FIPS_KEY);
    bus.adv = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    bus.ld = 1'b1; bus.key = k2; tick();
    bus.ld = 1'b0; bus.adv = 1'b0;
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    exp = {k2, 4'd0, 1'b1, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL ld_beats_adv: got %h exp %h", got, exp); end
    expand(k2);
    bus.adv = 1'b1; tick(); bus.adv = 1'b0;
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    exp = {sched[1], 4'd1, 1'b1, 1'b0};
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL ld_adv_then_r1: got %h exp %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [133:0] got, exp;
    do_load(FIPS_KEY);
    bus.adv = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b0; bus.ld = 1'b1; bus.key = FIPS_KEY;
    tick();
    got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
    exp = '0;
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL reset_mid: got %h exp %h", got, exp); end
    rst = 1'b1; bus.ld = 1'b0; bus.adv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL post_reset_adv %0d: got %h exp %h", i, got, exp); end
    end
    bus.adv = 1'b0;
  endtask

  task automatic test_random_keys();
    logic [133:0] got, exp;
    logic [127:0] k;
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      expand(k);
      do_load(k);
      bus.adv = 1'b1;
      for (int r = 1; r <= 10; r++) tick();
      bus.adv = 1'b0;
      got = {bus.rk, bus.rnd, bus.rk_valid, bus.done};
      exp = {sched[10], 4'd10, 1'b1, 1'b1};
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL rand_key%0d r10: got %h exp %h", t, got, exp); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    bus.ld   = 1'b0;
    bus.adv  = 1'b0;
    bus.key  = '0;
    build_sbox();
    test_reset();
    test_fips_back_to_back();
    test_zero_key();
    test_random_gaps();
    test_reload_mid();
    test_ld_adv_same();
    test_reset_mid();
    test_random_keys();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
